uart_word_loader: RTL and testbench

- Parametrised successor to the byte-wide UART image receiver.
- Receives a serial UART stream, validates framing and optional parity, and packs WORD_BYTES consecutive bytes into one memory word.
- Writes each word to a block-RAM port at consecutive addresses from base_addr through last_addr, then signals completion.
- Sits between the board RxD pin and the instruction/data BRAM write port during program load.

---
 rtl/uart_word_loader_if.sv | 33 +++
 rtl/uart_word_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_word_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_loader_if.sv
// Bus between the word loader and its environment: the serial input and
// address window in, the BRAM write port and status flags out.
interface uart_word_loader_if #(
  parameter int ADDR_W     = 14,
  parameter int WORD_BYTES = 1
);
  logic                    ena;
  logic                    rxd;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W-1:0]       last_addr;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*WORD_BYTES-1:0] mem_din;
  logic                    load_done;
  logic                    frame_err;
  logic                    parity_err;
  logic [ADDR_W:0]         word_count;

  // Loader side
  modport slave (
    input  ena, rxd, base_addr, last_addr,
    output mem_en, mem_we, mem_addr, mem_din, load_done, frame_err,
           parity_err, word_count
  );

  // Environment side
  modport master (
    output ena, rxd, base_addr, last_addr,
    input  mem_en, mem_we, mem_addr, mem_din, load_done, frame_err,
           parity_err, word_count
  );
endinterface

// File: rtl/uart_word_loader.sv
// UART receiver that packs WORD_BYTES bytes per word and writes the words
// into a BRAM from base_addr up to last_addr, then stops for good.
module uart_word_loader #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 9_600,
  parameter int OVERSAMPLE    = 16,
  parameter int WORD_BYTES    = 1,
  parameter int ADDR_W        = 14,
  parameter int PARITY        = 0,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_word_loader_if.slave   bus
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic            tick;
  logic [SW-1:0]   samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic            rxd_s1, rxd_s;
  logic            shift_en, par_en, stop_en;
  logic [7:0]      shreg;
  logic            par_bit, par_ok;
  logic [BW-1:0]   byte_idx, lane;
  logic            idx_last, pend, last_write;

  assign bus.mem_en = bus.ena;
  assign tick       = (div_q == DW'(DIV - 1));
  assign idx_last   = (byte_idx == BW'(WORD_BYTES - 1));
  assign last_write = bus.mem_we && (bus.mem_addr == bus.last_addr);
  assign lane       = (LITTLE_ENDIAN != 0) ? byte_idx
                                           : BW'(WORD_BYTES - 1) - byte_idx;

  // Even parity wants the XOR over data+parity to be 0, odd wants 1
  always_comb begin
    par_ok = 1'b1;
    if (PARITY == 1) par_ok = ~^{shreg, par_bit};
    else if (PARITY == 2) par_ok = ^{shreg, par_bit};
  end

  // Two-flop synchroniser for the asynchronous pin; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_s1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_s1 <= bus.rxd;
      rxd_s  <= rxd_s1;
    end
  end

  // Free-running oversample tick generator
  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else if (tick) div_q <= '0;
    else div_q <= div_q + DW'(1);
  end

  // FSM and sample/bit counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
    end
  end

  // Next state: the sample counter is re-zeroed at mid start bit, so each
  // later wrap at SAMP_LAST lands in the middle of the following bit
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    case (state_q)
      IDLE: if (tick && bus.ena && !rxd_s) begin
        state_d = START;
        samp_d  = '0;
      end
      START: if (tick) begin
        if (samp_q == SAMP_HALF) begin
          samp_d = '0;
          if (rxd_s) state_d = IDLE;
          else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else samp_d = samp_q + SW'(1);
      end
      DATA: if (tick) begin
        if (samp_q == SAMP_LAST) begin
          samp_d   = '0;
          shift_en = 1'b1;
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
        end else samp_d = samp_q + SW'(1);
      end
      PAR: if (tick) begin
        if (samp_q == SAMP_LAST) begin
          samp_d  = '0;
          par_en  = 1'b1;
          state_d = STOP;
        end else samp_d = samp_q + SW'(1);
      end
      STOP: if (tick) begin
        if (samp_q == SAMP_LAST) begin
          samp_d  = '0;
          stop_en = 1'b1;
          state_d = IDLE;
        end else samp_d = samp_q + SW'(1);
      end
      default: ;
    endcase
    if (last_write) state_d = DONE;
  end

  // Byte assembly, word commit (held while ena=0), address/flag tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg          <= '0;
      par_bit        <= 1'b0;
      byte_idx       <= '0;
      pend           <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_din    <= '0;
      bus.mem_addr   <= bus.base_addr;
      bus.word_count <= '0;
      bus.load_done  <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
      if (par_en) par_bit <= rxd_s;
      if (stop_en) begin
        if (!rxd_s) bus.frame_err <= 1'b1;
        else if (!par_ok) bus.parity_err <= 1'b1;
        else begin
          for (int i = 0; i < WORD_BYTES; i++)
            if (lane == BW'(i)) bus.mem_din[8*i +: 8] <= shreg;
          if (idx_last) begin
            if (bus.ena) bus.mem_we <= 1'b1;
            else pend <= 1'b1;
          end else byte_idx <= byte_idx + BW'(1);
        end
      end
      if (pend && bus.ena) begin
        bus.mem_we <= 1'b1;
        pend       <= 1'b0;
      end
      if (bus.mem_we) begin
        bus.word_count <= bus.word_count + (ADDR_W+1)'(1);
        byte_idx       <= '0;
        if (bus.mem_addr == bus.last_addr) bus.load_done <= 1'b1;
        else bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: two instances (4-byte LE with even
// parity, 2-byte BE without parity), scoreboarded BRAM writes.
module tb_uart_word_loader;
  localparam int BIT_CLKS = 160;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_pass = 0;
  int   n_fail = 0;
  wr_t  exp_a[$];
  wr_t  exp_b[$];
  logic we_prev_a = 1'b0;
  logic we_prev_b = 1'b0;

  always #5 clk = ~clk;

  uart_word_loader_if #(.ADDR_W(14), .WORD_BYTES(4)) ifa ();
  uart_word_loader_if #(.ADDR_W(14), .WORD_BYTES(2)) ifb ();

  uart_word_loader #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
    .WORD_BYTES(4), .ADDR_W(14), .PARITY(1), .LITTLE_ENDIAN(1)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

  uart_word_loader #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
    .WORD_BYTES(2), .ADDR_W(14), .PARITY(0), .LITTLE_ENDIAN(0)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) ifa.rxd = v;
    else ifb.rxd = v;
  endtask

  // One frame: start, 8 data LSB first, optional parity, stop, then idle high
  task automatic send(input int d, input logic [7:0] b, input logic use_par,
                      input logic pb, input logic sb, input logic drop_ena);
    set_rx(d, 1'b0);
    wait_clks(BIT_CLKS);
    if (drop_ena) ifa.ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_rx(d, b[i]);
      wait_clks(BIT_CLKS);
    end
    if (use_par) begin
      set_rx(d, pb);
      wait_clks(BIT_CLKS);
    end
    set_rx(d, sb);
    wait_clks(BIT_CLKS);
    set_rx(d, 1'b1);
  endtask

  task automatic send_a(input logic [7:0] b);
    send(0, b, 1'b1, ^b, 1'b1, 1'b0);
  endtask

  task automatic send_b(input logic [7:0] b);
    send(1, b, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Scoreboard: every write must be expected, one cycle wide, and match
  always @(negedge clk) begin
    if (ifa.mem_we) begin
      chk("a_we_expected", 64'(exp_a.size() > 0), 64'd1);
      chk("a_we_single", 64'(we_prev_a), 64'd0);
      if (exp_a.size() > 0) begin
        wr_t e;
        e = exp_a.pop_front();
        chk("a_wr_addr", 64'(ifa.mem_addr), 64'(e.addr));
        chk("a_wr_data", 64'(ifa.mem_din), 64'(e.data));
      end
    end
    if (ifb.mem_we) begin
      chk("b_we_expected", 64'(exp_b.size() > 0), 64'd1);
      chk("b_we_single", 64'(we_prev_b), 64'd0);
      if (exp_b.size() > 0) begin
        wr_t e;
        e = exp_b.pop_front();
        chk("b_wr_addr", 64'(ifb.mem_addr), 64'(e.addr));
        chk("b_wr_data", 64'(ifb.mem_din), 64'(e.data[15:0]));
      end
    end
    we_prev_a = ifa.mem_we;
    we_prev_b = ifb.mem_we;
  end

  initial begin
    ifa.ena = 1'b1; ifa.rxd = 1'b1; ifa.base_addr = 14'h010; ifa.last_addr = 14'h01F;
    ifb.ena = 1'b1; ifb.rxd = 1'b1; ifb.base_addr = 14'h000; ifb.last_addr = 14'h001;
    wait_clks(4);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_clks(1);

    // Reset state
    chk("a_rst_we", 64'(ifa.mem_we), 64'd0);
    chk("a_rst_addr", 64'(ifa.mem_addr), 64'h010);
    chk("a_rst_din", 64'(ifa.mem_din), 64'd0);
    chk("a_rst_cnt", 64'(ifa.word_count), 64'd0);
    chk("a_rst_flags", 64'({ifa.load_done, ifa.frame_err, ifa.parity_err}), 64'd0);
    chk("b_rst_addr", 64'(ifb.mem_addr), 64'h000);

    // B: short low glitch must not start a frame
    ifb.rxd = 1'b0;
    wait_clks(30);
    ifb.rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("b_glitch_flags", 64'({ifb.frame_err, ifb.parity_err}), 64'd0);
    chk("b_glitch_cnt", 64'(ifb.word_count), 64'd0);

    // B: big-endian 2-byte words, run to last_addr, then ignore input
    exp_b.push_back('{addr: 14'h000, data: 32'h0000_AABB});
    exp_b.push_back('{addr: 14'h001, data: 32'h0000_CCDD});
    send_b(8'hAA); send_b(8'hBB); send_b(8'hCC); send_b(8'hDD);
    wait_clks(20);
    chk("b_done", 64'(ifb.load_done), 64'd1);
    chk("b_cnt2", 64'(ifb.word_count), 64'd2);
    chk("b_addr_hold", 64'(ifb.mem_addr), 64'h001);
    send_b(8'hEE);
    wait_clks(2 * BIT_CLKS);
    chk("b_after_done_cnt", 64'(ifb.word_count), 64'd2);
    chk("b_after_done_din", 64'(ifb.mem_din), 64'hCCDD);

    // A: little-endian 4-byte word
    exp_a.push_back('{addr: 14'h010, data: 32'h1234_5678});
    send_a(8'h78); send_a(8'h56); send_a(8'h34); send_a(8'h12);
    wait_clks(20);
    chk("a_cnt1", 64'(ifa.word_count), 64'd1);
    chk("a_addr1", 64'(ifa.mem_addr), 64'h011);

    // A: bad even parity discards the byte, good parity accepts it
    send(0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_clks(20);
    chk("a_par_err", 64'(ifa.parity_err), 64'd1);
    chk("a_par_din_kept", 64'(ifa.mem_din), 64'h1234_5678);
    send(0, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_clks(20);
    chk("a_par_ok_din", 64'(ifa.mem_din), 64'h1234_5603);

    // A: stop bit low is a framing error and discards the byte
    send(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_clks(2 * BIT_CLKS);
    chk("a_frame_err", 64'(ifa.frame_err), 64'd1);
    chk("a_frame_din_kept", 64'(ifa.mem_din), 64'h1234_5603);
    chk("a_frame_cnt", 64'(ifa.word_count), 64'd1);

    // A: reset after start + 3 data bits aborts everything
    ifa.rxd = 1'b0; wait_clks(BIT_CLKS);
    ifa.rxd = 1'b1; wait_clks(BIT_CLKS);
    ifa.rxd = 1'b0; wait_clks(BIT_CLKS);
    ifa.rxd = 1'b1; wait_clks(BIT_CLKS);
    rst_a = 1'b1;
    wait_clks(3);
    rst_a = 1'b0;
    wait_clks(1);
    chk("a_mid_rst_addr", 64'(ifa.mem_addr), 64'h010);
    chk("a_mid_rst_din", 64'(ifa.mem_din), 64'd0);
    chk("a_mid_rst_cnt", 64'(ifa.word_count), 64'd0);
    chk("a_mid_rst_flags", 64'({ifa.load_done, ifa.frame_err, ifa.parity_err}), 64'd0);
    wait_clks(2 * BIT_CLKS);
    exp_a.push_back('{addr: 14'h010, data: 32'hCAFE_F00D});
    send_a(8'h0D); send_a(8'hF0); send_a(8'hFE); send_a(8'hCA);
    wait_clks(20);
    chk("a_post_rst_cnt", 64'(ifa.word_count), 64'd1);
    chk("a_post_rst_addr", 64'(ifa.mem_addr), 64'h011);

    // A: word completes with ena=0; commit waits for ena
    send_a(8'h11); send_a(8'h22); send_a(8'h33);
    send(0, 8'h44, 1'b1, ^8'h44, 1'b1, 1'b1);
    wait_clks(200);
    chk("a_ena_off_en", 64'(ifa.mem_en), 64'd0);
    chk("a_ena_off_cnt", 64'(ifa.word_count), 64'd1);
    chk("a_ena_off_addr", 64'(ifa.mem_addr), 64'h011);
    exp_a.push_back('{addr: 14'h011, data: 32'h4433_2211});
    ifa.ena = 1'b1;
    wait_clks(5);
    chk("a_ena_on_cnt", 64'(ifa.word_count), 64'd2);
    chk("a_ena_on_addr", 64'(ifa.mem_addr), 64'h012);
    chk("a_ena_on_done", 64'(ifa.load_done), 64'd0);

    wait_clks(5);
    chk("a_sb_empty", 64'(exp_a.size()), 64'd0);
    chk("b_sb_empty", 64'(exp_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
